// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared states, digit width and default timing for the whack-a-mole game
package whack_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_MOLE = 2'd1,
      ST_PLAY      = 2'd2,
      ST_OVER      = 2'd3
   } state_t;

   localparam int BCD_W = 4;

   localparam int T_START_DEF = 100_000_000;
   localparam int T_STEP_DEF  = 5_000_000;
   localparam int T_MIN_DEF   = 20_000_000;

endpackage

// File: rtl/bcd_score_counter.sv
// rtl/bcd_score_counter.sv - saturating multi-digit BCD up-counter
module bcd_score_counter
   import whack_pkg::*;
#(
   parameter int SCORE_DIGITS = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   input  logic                          inc,
   output logic [BCD_W*SCORE_DIGITS-1:0] score_bcd,
   output logic                          sat
);

   logic [BCD_W*SCORE_DIGITS-1:0] incremented;
   logic                          carry;

   // ripple a decimal carry upward from digit 0
   always_comb begin
      incremented = score_bcd;
      carry       = 1'b1;
      for (int i = 0; i < SCORE_DIGITS; i++) begin
         if (carry) begin
            if (score_bcd[i*BCD_W +: BCD_W] == 4'd9) begin
               incremented[i*BCD_W +: BCD_W] = 4'd0;
            end else begin
               incremented[i*BCD_W +: BCD_W] = score_bcd[i*BCD_W +: BCD_W] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   end

   // all digits at 9 means the score can no longer grow
   always_comb begin
      sat = 1'b1;
      for (int i = 0; i < SCORE_DIGITS; i++) begin
         if (score_bcd[i*BCD_W +: BCD_W] != 4'd9) sat = 1'b0;
      end
   end

   // score register; holds at all-9s instead of wrapping
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         score_bcd <= '0;
      end else if (inc && !sat) begin
         score_bcd <= incremented;
      end
   end

endmodule

// File: rtl/whack_game_ctrl.sv
// rtl/whack_game_ctrl.sv - game-round controller: timeout, lives, modes and BCD score
module whack_game_ctrl
   import whack_pkg::*;
#(
   parameter int N_POS        = 8,
   parameter int SCORE_DIGITS = 4,
   parameter int T_START      = T_START_DEF,
   parameter int T_STEP       = T_STEP_DEF,
   parameter int T_MIN        = T_MIN_DEF,
   parameter int LIVES        = 3,
   parameter int POS_W        = $clog2(N_POS),
   parameter int LIFE_W       = $clog2(LIVES + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          restart,
   input  logic                          mode_endless,
   input  logic                          eval_now,
   input  logic [POS_W-1:0]              user_guess,
   input  logic [POS_W-1:0]              mole_pos,
   input  logic                          mole_changed,
   output logic                          guess_correct,
   output logic                          guess_wrong,
   output logic [BCD_W*SCORE_DIGITS-1:0] score_bcd,
   output logic [LIFE_W-1:0]             lives_left,
   output logic                          game_over,
   output logic                          playing
);

   localparam int TW = $clog2(T_START + 1);

   state_t          state, state_next;
   logic [TW-1:0]   timer, timeout, timeout_next;
   logic [TW:0]     diff;
   logic            endless;
   logic            start, hit, miss, load_timer, dec_timer, expired;
   logic            sat;

   // the timer is loaded with the full timeout, so the miss fires on the
   // cycle it would count down to zero: exactly timeout cycles after PLAY
   assign expired = (timer <= TW'(1));

   // shrink the timeout after a hit; the extra bit catches underflow before clamping
   always_comb begin
      diff = {1'b0, timeout} - (TW+1)'(T_STEP);
      if (diff[TW] || diff < (TW+1)'(T_MIN)) timeout_next = TW'(T_MIN);
      else                                   timeout_next = diff[TW-1:0];
   end

   // next-state and per-cycle event decode
   always_comb begin
      state_next = state;
      start      = 1'b0;
      hit        = 1'b0;
      miss       = 1'b0;
      load_timer = 1'b0;
      dec_timer  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (restart) begin
               start      = 1'b1;
               state_next = ST_WAIT_MOLE;
            end
         end
         ST_WAIT_MOLE: begin
            if (restart) begin
               start      = 1'b1;
               state_next = ST_WAIT_MOLE;
            end else if (mole_changed) begin
               load_timer = 1'b1;
               state_next = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (restart) begin
               start      = 1'b1;
               state_next = ST_WAIT_MOLE;
            end else if (eval_now && user_guess == mole_pos) begin
               hit        = 1'b1;
               state_next = ST_WAIT_MOLE;
            end else if (eval_now || expired) begin
               miss = 1'b1;
               if (!endless && lives_left == LIFE_W'(1)) state_next = ST_OVER;
               else                                       state_next = ST_WAIT_MOLE;
            end else begin
               dec_timer = 1'b1;
            end
         end
         ST_OVER: begin
            if (restart) begin
               start      = 1'b1;
               state_next = ST_WAIT_MOLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // state, timer, lives, mode latch and registered pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         timer         <= TW'(T_START);
         timeout       <= TW'(T_START);
         lives_left    <= LIFE_W'(LIVES);
         endless       <= 1'b0;
         guess_correct <= 1'b0;
         guess_wrong   <= 1'b0;
      end else begin
         state         <= state_next;
         guess_correct <= hit;
         guess_wrong   <= miss;
         if (start) begin
            timeout    <= TW'(T_START);
            lives_left <= LIFE_W'(LIVES);
            endless    <= mode_endless;
         end else begin
            if (hit)              timeout    <= timeout_next;
            if (miss && !endless) lives_left <= lives_left - LIFE_W'(1);
         end
         if (load_timer)     timer <= timeout;
         else if (dec_timer) timer <= timer - TW'(1);
      end
   end

   bcd_score_counter #(
      .SCORE_DIGITS (SCORE_DIGITS)
   ) u_score (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (start),
      .inc       (hit),
      .score_bcd (score_bcd),
      .sat       (sat)
   );

   assign game_over = (state == ST_OVER);
   assign playing   = (state == ST_PLAY) || (state == ST_WAIT_MOLE);

endmodule

// File: tb/tb_whack_game_ctrl.sv
// tb/tb_whack_game_ctrl.sv - directed self-checking bench for whack_game_ctrl
module tb_whack_game_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, restart, mode_endless, eval_now, mole_changed;
   logic [2:0]  user_guess, mole_pos;
   logic        guess_correct, guess_wrong, game_over, playing;
   logic [15:0] score_bcd;
   logic [1:0]  lives_left;

   int errors = 0;
   int checks = 0;
   int n;
   int missed_pulses;

   whack_game_ctrl #(
      .N_POS        (8),
      .SCORE_DIGITS (4),
      .T_START      (10),
      .T_STEP       (1),
      .T_MIN        (4),
      .LIVES        (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .restart       (restart),
      .mode_endless  (mode_endless),
      .eval_now      (eval_now),
      .user_guess    (user_guess),
      .mole_pos      (mole_pos),
      .mole_changed  (mole_changed),
      .guess_correct (guess_correct),
      .guess_wrong   (guess_wrong),
      .score_bcd     (score_bcd),
      .lives_left    (lives_left),
      .game_over     (game_over),
      .playing       (playing)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_restart(input logic endless);
      mode_endless = endless;
      restart      = 1'b1;
      tick();
      restart      = 1'b0;
      mode_endless = 1'b0;
   endtask

   task automatic new_mole(input logic [2:0] p);
      mole_pos     = p;
      mole_changed = 1'b1;
      tick();
      mole_changed = 1'b0;
   endtask

   task automatic guess(input logic [2:0] g);
      user_guess = g;
      eval_now   = 1'b1;
      tick();
      eval_now   = 1'b0;
   endtask

   // cycles from entering PLAY until guess_wrong appears, -1 if it never does
   task automatic count_timeout(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 50; i++) begin
         tick();
         if (guess_wrong) begin
            cycles = i;
            break;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; restart = 1'b0; mode_endless = 1'b0; eval_now = 1'b0;
      mole_changed = 1'b0; user_guess = '0; mole_pos = '0;
      tick(); tick();
      check("rst_score", score_bcd, 16'h0000);
      check("rst_lives", lives_left, 2'd3);
      check("rst_over", game_over, 1'b0);
      check("rst_playing", playing, 1'b0);
      check("rst_pulses", {guess_correct, guess_wrong}, 2'b00);
      rst_n = 1'b1;
      tick();

      // untouched mole times out after T_START cycles and costs a life
      do_restart(1'b0);
      check("restart_playing", playing, 1'b1);
      new_mole(3'd3);
      count_timeout(n);
      check("timeout_10", n, 10);
      check("timeout_lives", lives_left, 2'd2);
      check("timeout_correct", guess_correct, 1'b0);

      // first hit
      do_restart(1'b0);
      check("restart_lives", lives_left, 2'd3);
      new_mole(3'd3);
      guess(3'd3);
      check("hit_pulse", {guess_correct, guess_wrong}, 2'b10);
      check("hit_score", score_bcd, 16'h0001);
      tick();
      check("hit_pulse_1cyc", guess_correct, 1'b0);
      check("hit_wait_playing", playing, 1'b1);
      guess(3'd3);
      check("wait_ignores_eval", {guess_correct, guess_wrong}, 2'b00);
      check("wait_score_held", score_bcd, 16'h0001);

      // nine more hits: decimal carry into digit 1, timeout clamps at 4
      for (int i = 0; i < 9; i++) begin
         new_mole(3'(i));
         guess(3'(i));
      end
      check("ten_hits_score", score_bcd, 16'h0010);
      new_mole(3'd5);
      count_timeout(n);
      check("timeout_clamped", n, 4);
      check("lives_after_clamp", lives_left, 2'd2);
      new_mole(3'd1);
      guess(3'd1);
      new_mole(3'd2);
      count_timeout(n);
      check("timeout_stays_min", n, 4);

      // three wrong guesses in lives mode
      do_restart(1'b0);
      new_mole(3'd4); guess(3'd1);
      check("wrong1_pulse", {guess_correct, guess_wrong}, 2'b01);
      check("wrong1_lives", lives_left, 2'd2);
      new_mole(3'd4); guess(3'd2);
      check("wrong2_lives", lives_left, 2'd1);
      check("wrong2_not_over", game_over, 1'b0);
      new_mole(3'd4); guess(3'd0);
      check("wrong3_lives", lives_left, 2'd0);
      check("wrong3_over", game_over, 1'b1);
      check("wrong3_playing", playing, 1'b0);
      new_mole(3'd4); guess(3'd4);
      check("over_ignores_eval", {guess_correct, guess_wrong}, 2'b00);
      check("over_score", score_bcd, 16'h0000);
      check("over_lives", lives_left, 2'd0);
      do_restart(1'b0);
      check("restart_from_over", {game_over, playing, lives_left}, 4'b0111);

      // endless mode: five timeouts cost nothing
      do_restart(1'b1);
      for (int i = 0; i < 5; i++) begin
         new_mole(3'd6);
         count_timeout(n);
         check("endless_timeout", n, 10);
         check("endless_lives", lives_left, 2'd3);
      end
      check("endless_not_over", game_over, 1'b0);
      new_mole(3'd6); guess(3'd2);
      check("endless_wrong_lives", lives_left, 2'd3);

      // restart beats a correct guess in PLAY
      new_mole(3'd7);
      user_guess = 3'd7; eval_now = 1'b1; restart = 1'b1; mode_endless = 1'b1;
      tick();
      eval_now = 1'b0; restart = 1'b0; mode_endless = 1'b0;
      check("restart_prio_pulse", {guess_correct, guess_wrong}, 2'b00);
      check("restart_prio_score", score_bcd, 16'h0000);

      // drive the score to 9999, then one more hit must saturate
      missed_pulses = 0;
      for (int i = 0; i < 9999; i++) begin
         new_mole(3'(i));
         guess(3'(i));
         if (!guess_correct) missed_pulses++;
      end
      check("fill_pulses", missed_pulses, 0);
      check("fill_score", score_bcd, 16'h9999);
      new_mole(3'd2);
      guess(3'd2);
      check("sat_pulse", guess_correct, 1'b1);
      check("sat_score", score_bcd, 16'h9999);

      // reset in the middle of PLAY, with a correct guess on the same edge
      new_mole(3'd5);
      rst_n = 1'b0; user_guess = 3'd5; eval_now = 1'b1;
      tick();
      eval_now = 1'b0;
      check("midrst_pulses", {guess_correct, guess_wrong}, 2'b00);
      check("midrst_score", score_bcd, 16'h0000);
      check("midrst_playing", playing, 1'b0);
      check("midrst_lives", lives_left, 2'd3);
      rst_n = 1'b1;
      mole_changed = 1'b1;
      tick();
      mole_changed = 1'b0;
      check("idle_ignores_mole", playing, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
